// File: rtl/srl_fifo.sv
// Shift-register FIFO: writes shift a common chain, reads index it by fill level,
// giving first-word-fall-through output with registered flow-control and error flags.
module srl_fifo #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned DEPTH     = 32,
  parameter int unsigned AFULL_LVL = 28,
  localparam int unsigned AW       = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ce,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  output logic             wr_full,
  output logic             almost_full,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             rd_valid,
  output logic [AW:0]      level,
  output logic             overflow,
  output logic             underflow
);

  localparam logic [AW:0] LVL_DEPTH = (AW+1)'(DEPTH);
  localparam logic [AW:0] LVL_AFULL = (AW+1)'(AFULL_LVL);
  localparam logic [AW:0] LVL_ONE   = (AW+1)'(1);

  logic [WIDTH-1:0] srl [DEPTH];
  logic             ra;
  logic             wa;
  logic [AW:0]      next_level;
  logic [AW-1:0]    rd_addr;

  // Accept decisions and next fill level
  always_comb begin
    ra         = ce & rd_en & (level != '0);
    wa         = ce & wr_en & ((level < LVL_DEPTH) | ra);
    next_level = level;
    if (wa && !ra)      next_level = level + LVL_ONE;
    else if (ra && !wa) next_level = level - LVL_ONE;
  end

  // Storage chain carries no reset so it can map onto SRL primitives
  always_ff @(posedge clk) begin
    if (wa) begin
      for (int i = DEPTH - 1; i > 0; i--) srl[i] <= srl[i-1];
      srl[0] <= wr_data;
    end
  end

  // Level and flags all derive from the next level so they never lag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level       <= '0;
      rd_valid    <= 1'b0;
      wr_full     <= 1'b0;
      almost_full <= 1'b0;
      overflow    <= 1'b0;
      underflow   <= 1'b0;
    end else if (ce) begin
      level       <= next_level;
      rd_valid    <= (next_level != '0);
      wr_full     <= (next_level == LVL_DEPTH);
      almost_full <= (next_level >= LVL_AFULL);
      overflow    <= wr_en & ~wa;
      underflow   <= rd_en & (level == '0);
    end
  end

  // Oldest word sits at level-1; an empty FIFO just shows srl[0]
  always_comb begin
    rd_addr = '0;
    if (level != '0) rd_addr = AW'(level - LVL_ONE);
  end

  assign rd_data = srl[rd_addr];

endmodule

// File: tb/tb_srl_fifo.sv
// Randomized bench for srl_fifo: queue-based reference model checked every cycle,
// plus directed sequences with hand-computed expectations.
module tb_srl_fifo;
  localparam int unsigned WIDTH = 8;
  localparam int unsigned DEPTH = 32;
  localparam int unsigned AFULL = 28;

  logic             clk = 1'b0;
  logic             rst_n, ce, wr_en, rd_en;
  logic [WIDTH-1:0] wr_data;
  logic             wr_full, almost_full, rd_valid, overflow, underflow;
  logic [WIDTH-1:0] rd_data;
  logic [5:0]       level;

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  // reference model: front of queue is the oldest word
  logic [WIDTH-1:0] q[$];
  bit m_ovf = 1'b0;
  bit m_unf = 1'b0;

  srl_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AFULL_LVL(AFULL)) dut (
    .clk(clk), .rst_n(rst_n), .ce(ce), .wr_en(wr_en), .wr_data(wr_data),
    .wr_full(wr_full), .almost_full(almost_full), .rd_en(rd_en),
    .rd_data(rd_data), .rd_valid(rd_valid), .level(level),
    .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // per-cycle comparison against the model
  always @(negedge clk) begin
    if (chk_en) begin
      chk("level",       64'(level),       64'(q.size()));
      chk("rd_valid",    64'(rd_valid),    64'(q.size() != 0));
      chk("wr_full",     64'(wr_full),     64'(q.size() == DEPTH));
      chk("almost_full", 64'(almost_full), 64'(q.size() >= AFULL));
      chk("overflow",    64'(overflow),    64'(m_ovf));
      chk("underflow",   64'(underflow),   64'(m_unf));
      if (q.size() != 0) chk("rd_data", 64'(rd_data), 64'(q[0]));
    end
  end

  // apply one cycle of stimulus, advance model at the edge, return after the compare edge
  task automatic cyc(input bit w, input logic [WIDTH-1:0] d, input bit r, input bit c);
    bit ra, wa;
    wr_en = w; wr_data = d; rd_en = r; ce = c;
    @(posedge clk);
    if (!rst_n) begin
      q.delete(); m_ovf = 1'b0; m_unf = 1'b0;
    end else if (c) begin
      ra = r && (q.size() != 0);
      wa = w && ((q.size() < DEPTH) || ra);
      m_ovf = w && !wa;
      m_unf = r && (q.size() == 0);
      if (ra) void'(q.pop_front());
      if (wa) q.push_back(d);
    end
    @(negedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; ce = 1'b1; wr_en = 1'b0; rd_en = 1'b0; wr_data = '0;
    repeat (3) cyc(0, 0, 0, 1);
    chk("reset_level", 64'(level), 64'd0);
    chk("reset_flags", 64'({rd_valid, wr_full, almost_full, overflow, underflow}), 64'd0);
    rst_n = 1'b1;
    chk_en = 1'b1;

    // fill 0x01..0x20
    for (int i = 1; i <= 32; i++) begin
      cyc(1, WIDTH'(i), 0, 1);
      if (i == 27) chk("af_below", 64'(almost_full), 64'd0);
      if (i == 28) chk("af_at28", 64'(almost_full), 64'd1);
      if (i == 31) chk("full_at31", 64'(wr_full), 64'd0);
    end
    chk("fill_level", 64'(level), 64'd32);
    chk("fill_full", 64'(wr_full), 64'd1);
    chk("fill_head", 64'(rd_data), 64'h01);

    // pass-through at full
    cyc(1, 8'hAA, 1, 1);
    chk("pt_level", 64'(level), 64'd32);
    chk("pt_ovf", 64'(overflow), 64'd0);
    chk("pt_head", 64'(rd_data), 64'h02);

    // overflow at full
    cyc(1, 8'h55, 0, 1);
    chk("ovf_pulse", 64'(overflow), 64'd1);
    chk("ovf_level", 64'(level), 64'd32);
    cyc(0, 0, 0, 1);
    chk("ovf_clear", 64'(overflow), 64'd0);
    chk("ovf_head", 64'(rd_data), 64'h02);

    // drain: 0x02..0x20 then 0xAA
    for (int i = 0; i < 31; i++) cyc(0, 0, 1, 1);
    chk("drain_aa", 64'(rd_data), 64'hAA);
    cyc(0, 0, 1, 1);
    chk("drain_empty", 64'(rd_valid), 64'd0);
    cyc(0, 0, 1, 1);
    chk("unf_pulse", 64'(underflow), 64'd1);
    chk("unf_level", 64'(level), 64'd0);

    // empty write+read accepts only the write
    cyc(1, 8'h7E, 1, 1);
    chk("ewr_level", 64'(level), 64'd1);
    chk("ewr_data", 64'(rd_data), 64'h7E);
    chk("ewr_unf", 64'(underflow), 64'd1);

    // randomized phase with alternating fill/drain bias
    for (int n = 0; n < 3000; n++) begin
      int bias;
      bias = ((n / 150) % 2 == 0) ? 8 : 2;
      cyc(($urandom_range(0, 9) < bias), WIDTH'($urandom),
          ($urandom_range(0, 9) >= bias), ($urandom_range(0, 7) != 0));
    end

    // reach level 5, then asynchronous reset between edges
    while (q.size() != 0) cyc(0, 0, 1, 1);
    for (int i = 0; i < 5; i++) cyc(1, WIDTH'(8'h10 + i), 0, 1);
    chk("pre_rst_level", 64'(level), 64'd5);
    #2;
    rst_n = 1'b0;
    q.delete(); m_ovf = 1'b0; m_unf = 1'b0;
    #1;
    chk("async_level", 64'(level), 64'd0);
    chk("async_flags", 64'({rd_valid, wr_full, almost_full, overflow, underflow}), 64'd0);
    cyc(0, 0, 0, 1);
    rst_n = 1'b1;
    cyc(1, 8'h33, 0, 0);
    chk("ce_gate_level", 64'(level), 64'd0);
    cyc(1, 8'h33, 0, 1);
    chk("post_rst_level", 64'(level), 64'd1);
    chk("post_rst_data", 64'(rd_data), 64'h33);

    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
